fir_channel_scheduler: RTL and testbench
========================================

// Module: fir_channel_scheduler
// PURPOSE
//  Time-shares one 31-tap FIR engine (8b signed in, 18b signed out, >=32 clk/sample)
//  among NUM_CH audio channels. Latches per-channel sample strobes, grants the
//  engine round-robin, pulses its ready strobe, waits out the compute window, and
//  returns each result tagged with its channel. The engine keeps one delay-line
//  bank per channel, selected by fir_ch_out.
// PARAMETERS
//  NUM_CH  4   number of requesting channels (2..8)
//  WINDOW  34  clocks from fir_ready_out pulse to result capture (>=33)
// PORTS
//  clk_in          in   1           system clock
//  rst_in          in   1           reset, synchronous, active-low
//  ch_valid_in     in   NUM_CH      1-clk strobe per channel: new sample present
//  ch_x_in         in   8*NUM_CH    signed samples; ch k at [8k+7:8k]
//  fir_ready_out   out  1           1-clk strobe to engine: sample on fir_x_out
//  fir_x_out       out  8           signed sample to engine
//  fir_ch_out      out  $clog2(NUM_CH)  engine bank select; held stable whole window
//  fir_y_in        in   18          signed engine result
//  y_out           out  18          signed filtered result (scaled by 2**10)
//  y_ch_out        out  $clog2(NUM_CH)  channel of y_out
//  y_valid_out     out  1           1-clk strobe: y_out/y_ch_out valid
//  overrun_out     out  NUM_CH      sticky: sample overwritten before service
//  busy_out        out  1           high in ISSUE/RUN/CAPTURE
// BEHAVIOUR
//  Reset (rst_in==0 at clk edge): all outputs 0, pending[] 0, holding regs 0,
//   state IDLE, rr pointer NUM_CH-1 (ch0 wins first). Reset mid-window abandons
//   the transaction: no y_valid_out; the engine is not re-pulsed.
//  Capture: ch_valid_in[k] -> hold[k]<=ch_x_in[k], pending[k]<=1. If pending[k]
//   is already 1 and not cleared this cycle, the sample is overwritten and
//   overrun_out[k]<=1 (cleared only by reset).
//  FSM IDLE->ISSUE->RUN->CAPTURE->IDLE:
//   IDLE: if any pending, grant first pending channel after rr pointer (wrap
//    NUM_CH-1->0); rr<=grant; fir_ch_out<=grant; ->ISSUE. Otherwise stay.
//   ISSUE (1 clk): fir_ready_out=1, fir_x_out=hold[grant]; pending[grant]<=0.
//    A simultaneous ch_valid_in[grant] wins: pending stays 1, new hold, no overrun.
//    ->RUN, cnt<=0.
//   RUN: cnt increments each clk; at cnt==WINDOW-2 ->CAPTURE.
//   CAPTURE (1 clk): y_out<=fir_y_in, y_ch_out<=grant, y_valid_out=1 next clk; ->IDLE.
//  Timing: ready pulse at cycle T, fir_y_in sampled at T+WINDOW, y_valid_out at
//   T+WINDOW+1. Service period is WINDOW+2 clks per sample; back-to-back grants
//   need no idle gap beyond IDLE's 1 clk.
//  y_out, y_ch_out hold between strobes. fir_x_out holds between ISSUE cycles.
//  Arithmetic: no computation on data; widths pass through unchanged (sign kept).
//  The scheduler owns capacity: all channels strobing at rate R requires
//   NUM_CH*(WINDOW+2) <= clocks per sample period, else overrun_out flags it.
// TESTING
//  1 Reset, ch1 strobe x=8'sd100 at t0 -> fir_ready_out at t0+2 with fir_x_out=100,
//    fir_ch_out=1; y_valid_out at t0+2+WINDOW+1 with y_ch_out=1, y_out=fir_y_in.
//  2 ch0,ch2,ch3 strobe same clk -> grant order 0,2,3, ready pulses spaced WINDOW+2.
//  3 ch2 strobes twice (-5 then 7) before its grant -> engine sees 7, overrun_out=4'b0100.
//  4 Strobe on the granted channel during its ISSUE clk -> pending stays set, second
//    grant follows, no overrun.
//  5 rst_in low mid-RUN -> all outputs 0 next clk, no y_valid_out; after release
//    ch3 strobe services normally with ch3 granted first.
//  6 All 4 channels strobe every 4*(WINDOW+2) clks for 100 periods -> 400 results,
//    strict 0,1,2,3 rotation, overrun_out stays 0.

Source files
------------

// File: rtl/fir_channel_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_channel_scheduler_if
// Brief    : Channel-side strobes/samples, FIR engine handshake and tagged
//            result bus for the FIR channel scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface fir_channel_scheduler_if #(
  parameter int NUM_CH = 4
);
  localparam int CHW = $clog2(NUM_CH);

  logic [NUM_CH-1:0]   ch_valid_in;
  logic [8*NUM_CH-1:0] ch_x_in;
  logic                fir_ready_out;
  logic signed [7:0]   fir_x_out;
  logic [CHW-1:0]      fir_ch_out;
  logic signed [17:0]  fir_y_in;
  logic signed [17:0]  y_out;
  logic [CHW-1:0]      y_ch_out;
  logic                y_valid_out;
  logic [NUM_CH-1:0]   overrun_out;
  logic                busy_out;

  // Scheduler side
  modport slave (
    input  ch_valid_in, ch_x_in, fir_y_in,
    output fir_ready_out, fir_x_out, fir_ch_out,
           y_out, y_ch_out, y_valid_out, overrun_out, busy_out
  );

  // Channel sources / engine / result consumer side
  modport master (
    output ch_valid_in, ch_x_in, fir_y_in,
    input  fir_ready_out, fir_x_out, fir_ch_out,
           y_out, y_ch_out, y_valid_out, overrun_out, busy_out
  );
endinterface
`default_nettype wire

// File: rtl/fir_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fir_channel_scheduler
// Brief    : Round-robin time-sharing of one multi-bank FIR engine among
//            NUM_CH channels; latches strobes, issues samples, waits out the
//            compute window and returns channel-tagged results.
// Revision : 1.0 - initial release
// ============================================================================
module fir_channel_scheduler #(
  parameter int NUM_CH = 4,
  parameter int WINDOW = 34
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  fir_channel_scheduler_if.slave bus
);
  localparam int CHW  = $clog2(NUM_CH);
  localparam int CNTW = $clog2(WINDOW);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WINDOW - 2);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RUN     = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic signed [7:0]  w_ch_x   [NUM_CH];
  logic signed [7:0]  w_hold   [NUM_CH];
  logic [NUM_CH-1:0]  w_pending;
  logic [NUM_CH-1:0]  w_overrun;
  logic [CHW-1:0]     r_rr;
  logic [CHW-1:0]     r_grant;
  logic [CHW-1:0]     w_grant;
  logic               w_any;
  int                 w_idx;
  logic signed [7:0]  w_x_next;
  logic [CNTW-1:0]    r_cnt;
  logic               r_ready;
  logic signed [7:0]  r_x;
  logic signed [17:0] r_y;
  logic [CHW-1:0]     r_y_ch;
  logic               r_y_valid;

  // Per-channel sample holding, pending flag and sticky overrun flag
  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    logic signed [7:0] r_hold_k;
    logic              r_pend_k;
    logic              r_ovr_k;
    logic              w_clr;

    assign w_ch_x[k]    = bus.ch_x_in[8*k +: 8];
    // The grant is consumed on the ISSUE clock of this channel
    assign w_clr        = (r_state == ST_ISSUE) && (r_grant == CHW'(k));
    assign w_hold[k]    = r_hold_k;
    assign w_pending[k] = r_pend_k;
    assign w_overrun[k] = r_ovr_k;

    // New strobe wins over a same-cycle grant clear, so no sample is lost
    always_ff @(posedge clk_in) begin
      if (!rst_in) begin
        r_hold_k <= '0;
        r_pend_k <= 1'b0;
        r_ovr_k  <= 1'b0;
      end else if (bus.ch_valid_in[k]) begin
        r_hold_k <= w_ch_x[k];
        r_pend_k <= 1'b1;
        if (r_pend_k && !w_clr) begin
          r_ovr_k <= 1'b1;
        end
      end else if (w_clr) begin
        r_pend_k <= 1'b0;
      end
    end
  end

  // Round-robin search: first pending channel strictly after the last grant
  always_comb begin
    w_any   = 1'b0;
    w_grant = r_rr;
    w_idx   = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_idx = (int'(r_rr) + i) % NUM_CH;
      if (!w_any && w_pending[CHW'(w_idx)]) begin
        w_any   = 1'b1;
        w_grant = CHW'(w_idx);
      end
    end
  end

  // Sample handed to the engine: a strobe landing on the grant edge is the freshest
  always_comb begin
    w_x_next = w_hold[w_grant];
    if (bus.ch_valid_in[w_grant]) begin
      w_x_next = w_ch_x[w_grant];
    end
  end

  // Next-state logic for the grant / compute / capture sequence
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_any) w_state_next = ST_ISSUE;
      ST_ISSUE:   w_state_next = ST_RUN;
      ST_RUN:     if (r_cnt == CNT_LAST) w_state_next = ST_CAPTURE;
      ST_CAPTURE: w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // State register plus the registered engine and result outputs
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state   <= ST_IDLE;
      r_rr      <= CHW'(NUM_CH - 1);
      r_grant   <= '0;
      r_cnt     <= '0;
      r_ready   <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_y_ch    <= '0;
      r_y_valid <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_ready   <= 1'b0;
      r_y_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_rr    <= w_grant;
            r_grant <= w_grant;
            r_ready <= 1'b1;
            r_x     <= w_x_next;
          end
        end
        ST_ISSUE: r_cnt <= '0;
        ST_RUN:   r_cnt <= r_cnt + CNTW'(1);
        ST_CAPTURE: begin
          r_y       <= bus.fir_y_in;
          r_y_ch    <= r_grant;
          r_y_valid <= 1'b1;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign bus.fir_ready_out = r_ready;
  assign bus.fir_x_out     = r_x;
  assign bus.fir_ch_out    = r_grant;
  assign bus.y_out         = r_y;
  assign bus.y_ch_out      = r_y_ch;
  assign bus.y_valid_out   = r_y_valid;
  assign bus.overrun_out   = w_overrun;
  assign bus.busy_out      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fir_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_channel_scheduler
// Brief    : Self-checking bench for fir_channel_scheduler with a behavioural
//            engine whose result is only valid on the exact capture clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_channel_scheduler;
  localparam int NUM_CH = 4;
  localparam int WINDOW = 34;
  localparam int PERIOD = WINDOW + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  fir_channel_scheduler_if #(.NUM_CH(NUM_CH)) bus ();

  fir_channel_scheduler #(.NUM_CH(NUM_CH), .WINDOW(WINDOW)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Cycle counter, read only on falling edges
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: result x*1024+ch present only WINDOW clocks after the ready pulse
  int eng_cnt = 1000;
  logic signed [17:0] eng_res = '0;
  always @(negedge clk) begin
    if (bus.fir_ready_out) begin
      eng_cnt = 0;
      eng_res = 18'(int'(bus.fir_x_out) * 1024 + int'(bus.fir_ch_out));
    end else if (eng_cnt < 1000) begin
      eng_cnt++;
    end
    bus.fir_y_in = (eng_cnt == WINDOW) ? eng_res : 18'sh15555;
  end

  // Result log
  int log_ch[$];
  int log_y[$];
  always @(negedge clk) begin
    if (bus.y_valid_out) begin
      log_ch.push_back(int'(bus.y_ch_out));
      log_y.push_back(int'(bus.y_out));
    end
  end

  function automatic int exp_y(input int ch, input int x);
    return x * 1024 + ch;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_zero(input string p);
    check({p, "_fir_ready"}, int'(bus.fir_ready_out), 0);
    check({p, "_fir_x"},     int'(bus.fir_x_out), 0);
    check({p, "_fir_ch"},    int'(bus.fir_ch_out), 0);
    check({p, "_y"},         int'(bus.y_out), 0);
    check({p, "_y_ch"},      int'(bus.y_ch_out), 0);
    check({p, "_y_valid"},   int'(bus.y_valid_out), 0);
    check({p, "_overrun"},   int'(bus.overrun_out), 0);
    check({p, "_busy"},      int'(bus.busy_out), 0);
  endtask

  // Called right after a falling edge; strobe lasts exactly one clock
  task automatic strobe(input logic [3:0] mask, input int x0, input int x1,
                        input int x2, input int x3);
    bus.ch_valid_in = mask;
    bus.ch_x_in     = {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
    @(negedge clk);
    bus.ch_valid_in = '0;
  endtask

  task automatic strobe1(input int ch, input int x);
    logic [31:0] v;
    v = '0;
    v[8*ch +: 8] = 8'(x);
    strobe(4'(1 << ch), int'(v[7:0]), int'(v[15:8]), int'(v[23:16]), int'(v[31:24]));
  endtask

  task automatic wait_ready(input int budget, output int ch, output int x, output int at);
    at = -1; ch = -1; x = 0;
    for (int i = 0; i < budget && at < 0; i++) begin
      @(negedge clk);
      if (bus.fir_ready_out) begin
        ch = int'(bus.fir_ch_out);
        x  = int'(bus.fir_x_out);
        at = cyc;
      end
    end
  endtask

  task automatic wait_valid(input int budget, input int hold_ch,
                            output int ch, output int y, output int at);
    int bad;
    bad = 0; at = -1; ch = -1; y = 0;
    for (int i = 0; i < budget && at < 0; i++) begin
      @(negedge clk);
      if (bus.y_valid_out) begin
        ch = int'(bus.y_ch_out);
        y  = int'(bus.y_out);
        at = cyc;
      end else if (int'(bus.fir_ch_out) != hold_ch) begin
        bad++;
      end
    end
    check("fir_ch_held_in_window", bad, 0);
  endtask

  typedef struct {
    int ch;
    int x;
    int y;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int t0, rch, rx, rat, vch, vy, vat, prev_at, bad_ch, bad_y;
    int exp_q[$];
    int ord[3];
    int xs[3];

    vecs[0] = '{ch: 1, x:  100, y:  102401};
    vecs[1] = '{ch: 0, x: -128, y: -131072};
    vecs[2] = '{ch: 2, x:  127, y:  130050};
    vecs[3] = '{ch: 3, x:   -1, y:   -1021};
    vecs[4] = '{ch: 0, x:    0, y:       0};
    vecs[5] = '{ch: 1, x:  -37, y:  -37887};
    vecs[6] = '{ch: 3, x:   64, y:   65539};

    bus.ch_valid_in = '0;
    bus.ch_x_in     = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single-channel transactions: latency, data path, tagging
    for (int i = 0; i < 7; i++) begin
      t0 = cyc;
      strobe1(vecs[i].ch, vecs[i].x);
      wait_ready(8, rch, rx, rat);
      check("v_ready_seen", int'(rat >= 0), 1);
      check("v_ready_delay", rat - t0, 2);
      check("v_fir_ch", rch, vecs[i].ch);
      check("v_fir_x", rx, vecs[i].x);
      check("v_busy_issue", int'(bus.busy_out), 1);
      wait_valid(WINDOW + 8, vecs[i].ch, vch, vy, vat);
      check("v_valid_seen", int'(vat >= 0), 1);
      check("v_valid_delay", vat - rat, WINDOW + 1);
      check("v_y_ch", vch, vecs[i].ch);
      check("v_y", vy, vecs[i].y);
      check("v_busy_done", int'(bus.busy_out), 0);
      @(negedge clk);
      check("v_valid_pulse", int'(bus.y_valid_out), 0);
      check("v_y_hold", int'(bus.y_out), vecs[i].y);
      @(negedge clk);
    end

    // ch0, ch2, ch3 together: round-robin order and back-to-back spacing
    ord = '{0, 2, 3};
    xs  = '{10, -20, 30};
    strobe(4'b1101, 10, 0, -20, 30);
    prev_at = 0;
    for (int j = 0; j < 3; j++) begin
      wait_ready(PERIOD + 8, rch, rx, rat);
      check("rr_ready_seen", int'(rat >= 0), 1);
      check("rr_order", rch, ord[j]);
      check("rr_x", rx, xs[j]);
      if (j > 0) check("rr_spacing", rat - prev_at, PERIOD);
      prev_at = rat;
      wait_valid(WINDOW + 8, ord[j], vch, vy, vat);
      check("rr_y_ch", vch, ord[j]);
      check("rr_y", vy, exp_y(ord[j], xs[j]));
    end
    check("rr_overrun", int'(bus.overrun_out), 0);
    repeat (3) @(negedge clk);

    // Strobe on the granted channel during its ISSUE clock
    strobe1(1, 45);
    wait_ready(8, rch, rx, rat);
    check("iss_first_x", rx, 45);
    strobe1(1, -46);
    wait_valid(WINDOW + 8, 1, vch, vy, vat);
    check("iss_first_y", vy, exp_y(1, 45));
    prev_at = rat;
    wait_ready(8, rch, rx, rat);
    check("iss_second_seen", int'(rat >= 0), 1);
    check("iss_second_ch", rch, 1);
    check("iss_second_x", rx, -46);
    check("iss_second_spacing", rat - prev_at, PERIOD);
    wait_valid(WINDOW + 8, 1, vch, vy, vat);
    check("iss_second_y", vy, exp_y(1, -46));
    check("iss_overrun", int'(bus.overrun_out), 0);
    wait_ready(PERIOD, rch, rx, rat);
    check("iss_no_third_grant", rat, -1);

    // ch2 overwritten before service while ch0 holds the engine
    log_ch.delete();
    log_y.delete();
    strobe1(0, 11);
    repeat (3) @(negedge clk);
    strobe1(2, -5);
    repeat (3) @(negedge clk);
    strobe1(2, 7);
    repeat (2 * PERIOD + 10) @(negedge clk);
    check("ovr_results", log_ch.size(), 2);
    if (log_ch.size() == 2) begin
      check("ovr_first_ch", log_ch[0], 0);
      check("ovr_first_y", log_y[0], exp_y(0, 11));
      check("ovr_second_ch", log_ch[1], 2);
      check("ovr_second_y", log_y[1], exp_y(2, 7));
    end
    check("ovr_flags", int'(bus.overrun_out), 4);

    // Reset in the middle of RUN abandons the transaction
    strobe1(1, 33);
    wait_ready(8, rch, rx, rat);
    check("rst_ready_seen", int'(rat >= 0), 1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    log_ch.delete();
    log_y.delete();
    repeat (WINDOW + 5) @(negedge clk);
    check("midrst_no_result", log_ch.size(), 0);
    t0 = cyc;
    strobe1(3, -77);
    wait_ready(8, rch, rx, rat);
    check("midrst_ready_delay", rat - t0, 2);
    check("midrst_grant_ch", rch, 3);
    check("midrst_x", rx, -77);
    wait_valid(WINDOW + 8, 3, vch, vy, vat);
    check("midrst_y_ch", vch, 3);
    check("midrst_y", vy, exp_y(3, -77));
    @(negedge clk);

    // Full-rate load: all channels every NUM_CH*(WINDOW+2) clocks
    log_ch.delete();
    log_y.delete();
    for (int p = 0; p < 100; p++) begin
      int x4[4];
      for (int k = 0; k < 4; k++) begin
        x4[k] = ((p * 37 + k * 59) % 256) - 128;
        exp_q.push_back(exp_y(k, x4[k]));
      end
      strobe(4'hF, x4[0], x4[1], x4[2], x4[3]);
      repeat (NUM_CH * PERIOD - 1) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check("load_results", log_ch.size(), 400);
    bad_ch = 0;
    bad_y  = 0;
    for (int i = 0; i < log_ch.size() && i < 400; i++) begin
      if (log_ch[i] != i % 4) bad_ch++;
      if (log_y[i] != exp_q[i]) bad_y++;
    end
    check("load_rotation_errors", bad_ch, 0);
    check("load_data_errors", bad_y, 0);
    check("load_overrun", int'(bus.overrun_out), 0);
    check("load_idle", int'(bus.busy_out), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
